// File: rtl/rect_fill_master_if.sv
// ---------------------------------------------------------------------------
// rect_fill_master_if
//   Bus bundle for rect_fill_master: the CSR slave port (from the PCIe
//   bridge), the pixel-write master port (to the SDRAM controller) and irq.
//
//   modport master : view of the fill block itself (answers CSR accesses,
//                    issues pixel writes, raises irq)
//   modport slave  : view of the surroundings (CSR host + memory slave)
//
//   Signals
//     slave_address / slave_writedata / slave_write / slave_read /
//     slave_chipselect        CSR access from the host
//     slave_readdata          CSR read data, registered, latency 1
//     master_address          pixel byte address
//     master_writedata        pixel colour
//     master_write            write request
//     master_waitrequest      memory stall
//     irq                     DONE & IRQ_EN level interrupt
// ---------------------------------------------------------------------------
interface rect_fill_master_if #(
  parameter int MASTER_ADDRESSWIDTH = 32,
  parameter int SLAVE_ADDRESSWIDTH  = 3,
  parameter int DATAWIDTH           = 32
);
  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address;
  logic [DATAWIDTH-1:0]           slave_writedata;
  logic                           slave_write;
  logic                           slave_read;
  logic                           slave_chipselect;
  logic [DATAWIDTH-1:0]           slave_readdata;
  logic [MASTER_ADDRESSWIDTH-1:0] master_address;
  logic [DATAWIDTH-1:0]           master_writedata;
  logic                           master_write;
  logic                           master_waitrequest;
  logic                           irq;

  modport master (
    input  slave_address, slave_writedata, slave_write, slave_read,
           slave_chipselect, master_waitrequest,
    output slave_readdata, master_address, master_writedata, master_write, irq
  );

  modport slave (
    output slave_address, slave_writedata, slave_write, slave_read,
           slave_chipselect, master_waitrequest,
    input  slave_readdata, master_address, master_writedata, master_write, irq
  );
endinterface

// File: rtl/rect_fill_master.sv
// ---------------------------------------------------------------------------
// rect_fill_master
//   Fills a rectangle of a linear 32-bit-per-pixel frame buffer with a
//   programmable colour. The host programs geometry/colour/base/stride via
//   the CSR port and pulses START; the master port then emits one pixel
//   write per accepted transfer in raster order (1 pixel/cycle when not
//   stalled, no bubble at row change).
//
//   Ports
//     clk      single clock
//     reset_n  asynchronous active-low reset
//     bus      rect_fill_master_if.master (CSR slave, pixel master, irq)
//
//   CSR map (word index)
//     0 CTRL   b0 START (self-clear), b1 ABORT (self-clear), b2 IRQ_EN
//     1 STATUS b0 BUSY (RO), b1 DONE, b2 ERR, b3 ABORTED (W1C)
//     2 COLOR  3 ORIGIN {y0,x0}  4 EXTENT {y1,x1} (inclusive)
//     5 BASE   6 STRIDE (both word aligned)  7 COUNT (RO)
// ---------------------------------------------------------------------------
module rect_fill_master #(
  parameter int MASTER_ADDRESSWIDTH = 32,
  parameter int SLAVE_ADDRESSWIDTH  = 3,
  parameter int DATAWIDTH           = 32,
  parameter int COORDWIDTH          = 11
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rect_fill_master_if.master    bus
);

  localparam int AW = MASTER_ADDRESSWIDTH;
  localparam int DW = DATAWIDTH;
  localparam int CW = COORDWIDTH;

  typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_t;

  state_t        state;
  logic          irq_en, done, err, aborted, abort_pending;
  logic [DW-1:0] color, base, stride, count;
  logic [CW-1:0] x0, y0, x1, y1, x, y;
  logic [AW-1:0] row_addr;

  logic          csr_wr, csr_rd, busy, start_req, abort_req, geom_ok, accept;
  logic          last_pixel;
  logic [2:0]    reg_idx;
  logic [AW-1:0] row_start, next_row;
  logic [DW-1:0] rd_mux;

  assign reg_idx    = bus.slave_address[2:0];
  assign csr_wr     = bus.slave_write & bus.slave_chipselect;
  assign csr_rd     = bus.slave_read  & bus.slave_chipselect;
  assign busy       = (state != IDLE);
  assign start_req  = csr_wr && (reg_idx == 3'd0) && bus.slave_writedata[0];
  assign abort_req  = csr_wr && (reg_idx == 3'd0) && bus.slave_writedata[1];
  assign geom_ok    = (x1 >= x0) && (y1 >= y0);
  assign accept     = (state == WRITE) && !bus.master_waitrequest;
  assign last_pixel = (x == x1) && (y == y1);

  // All address arithmetic is done at master width so it wraps naturally.
  assign row_start = AW'(base) + AW'(stride) * AW'(y0) + (AW'(x0) << 2);
  assign next_row  = row_addr + AW'(stride);

  assign bus.irq = done & irq_en;

  // NOTE: every variable driven here gets a default first, otherwise the
  // unlisted register indices would infer a latch.
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      3'd0: rd_mux[2]   = irq_en;
      3'd1: rd_mux[3:0] = {aborted, err, done, busy};
      3'd2: rd_mux      = color;
      3'd3: begin
        rd_mux[16+:CW] = y0;
        rd_mux[0+:CW]  = x0;
      end
      3'd4: begin
        rd_mux[16+:CW] = y1;
        rd_mux[0+:CW]  = x1;
      end
      3'd5: rd_mux = base;
      3'd6: rd_mux = stride;
      3'd7: rd_mux = count;
      default: rd_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; where two
  // assignments to the same register happen in one cycle the later one in
  // this block wins, which is how "set beats W1C" is expressed below.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      irq_en               <= 1'b0;
      done                 <= 1'b0;
      err                  <= 1'b0;
      aborted              <= 1'b0;
      abort_pending        <= 1'b0;
      color                <= '0;
      base                 <= '0;
      stride               <= '0;
      count                <= '0;
      x0                   <= '0;
      y0                   <= '0;
      x1                   <= '0;
      y1                   <= '0;
      x                    <= '0;
      y                    <= '0;
      row_addr             <= '0;
      bus.slave_readdata   <= '0;
      bus.master_address   <= '0;
      bus.master_writedata <= '0;
      bus.master_write     <= 1'b0;
    end else begin
      if (csr_rd) bus.slave_readdata <= rd_mux;

      // Configuration is frozen while a fill is running.
      if (csr_wr && !busy) begin
        case (reg_idx)
          3'd2: color <= bus.slave_writedata;
          3'd3: begin
            x0 <= bus.slave_writedata[0+:CW];
            y0 <= bus.slave_writedata[16+:CW];
          end
          3'd4: begin
            x1 <= bus.slave_writedata[0+:CW];
            y1 <= bus.slave_writedata[16+:CW];
          end
          3'd5: base   <= {bus.slave_writedata[DW-1:2], 2'b00};
          3'd6: stride <= {bus.slave_writedata[DW-1:2], 2'b00};
          default: ;
        endcase
      end

      if (csr_wr && (reg_idx == 3'd0)) irq_en <= bus.slave_writedata[2];

      if (csr_wr && (reg_idx == 3'd1)) begin
        done    <= done    & ~bus.slave_writedata[1];
        err     <= err     & ~bus.slave_writedata[2];
        aborted <= aborted & ~bus.slave_writedata[3];
      end

      case (state)
        IDLE: begin
          if (start_req) begin
            count   <= '0;
            aborted <= 1'b0;
            if (geom_ok) begin
              state                <= SETUP;
              done                 <= 1'b0;
              err                  <= 1'b0;
              abort_pending        <= 1'b0;
              bus.master_writedata <= color;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end

        SETUP: begin
          if (abort_req) begin
            state   <= IDLE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else begin
            row_addr           <= row_start;
            bus.master_address <= row_start;
            x                  <= x0;
            y                  <= y0;
            bus.master_write   <= 1'b1;
            state              <= WRITE;
          end
        end

        WRITE: begin
          if (abort_req) abort_pending <= 1'b1;
          if (accept) begin
            count <= count + DW'(1);
            if (last_pixel || abort_req || abort_pending) begin
              bus.master_write <= 1'b0;
              state            <= IDLE;
              done             <= 1'b1;
              abort_pending    <= 1'b0;
              if (abort_req || abort_pending) aborted <= 1'b1;
            end else if (x == x1) begin
              x                  <= x0;
              y                  <= y + CW'(1);
              row_addr           <= next_row;
              bus.master_address <= next_row;
            end else begin
              x                  <= x + CW'(1);
              bus.master_address <= bus.master_address + AW'(4);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_master.sv
module tb_rect_fill_master;
  localparam int AW = 32;
  localparam int SAW = 3;
  localparam int DW = 32;
  localparam int CW = 11;

  localparam logic [2:0] R_CTRL = 3'd0, R_STATUS = 3'd1, R_COLOR = 3'd2,
                         R_ORIGIN = 3'd3, R_EXTENT = 3'd4, R_BASE = 3'd5,
                         R_STRIDE = 3'd6, R_COUNT = 3'd7;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rect_fill_master_if #(.MASTER_ADDRESSWIDTH(AW), .SLAVE_ADDRESSWIDTH(SAW),
                        .DATAWIDTH(DW)) bus ();

  rect_fill_master #(.MASTER_ADDRESSWIDTH(AW), .SLAVE_ADDRESSWIDTH(SAW),
                     .DATAWIDTH(DW), .COORDWIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory-side stall generator: stall_mode 1 holds each transfer 0-3 cycles.
  logic force_wait = 1'b0;
  logic rand_wait  = 1'b0;
  int   stall_mode = 0;
  int   stall_left = 0;
  bit   have_stall = 0;
  assign bus.master_waitrequest = force_wait | rand_wait;

  always @(negedge clk) begin
    if (stall_mode == 0 || !bus.master_write) begin
      rand_wait  = 1'b0;
      have_stall = 0;
    end else begin
      if (!have_stall) begin
        stall_left = $urandom_range(0, 3);
        have_stall = 1;
      end
      if (stall_left > 0) begin
        rand_wait = 1'b1;
        stall_left--;
      end else begin
        rand_wait  = 1'b0;
        have_stall = 0;
      end
    end
  end

  // Monitor: records accepted transfers and checks stability under stall.
  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  bit            was_stalled = 0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;

  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (was_stalled) begin
        check("hold_write", bus.master_write, 1'b1);
        check("hold_addr", bus.master_address, held_addr);
        check("hold_data", bus.master_writedata, held_data);
      end
      if (bus.master_write && !bus.master_waitrequest) begin
        obs_addr.push_back(bus.master_address);
        obs_data.push_back(bus.master_writedata);
      end
      was_stalled = bus.master_write && bus.master_waitrequest;
      held_addr   = bus.master_address;
      held_data   = bus.master_writedata;
    end else begin
      was_stalled = 0;
    end
  end

  // Reference model: raster-order pixel addresses from the geometry.
  logic [AW-1:0] exp_addr[$];

  task automatic build_expected(input logic [31:0] b, input logic [31:0] s,
                                input int x0, input int y0, input int x1,
                                input int y1, input int max_n);
    logic [31:0] ab, as;
    ab = b & ~32'h3;
    as = s & ~32'h3;
    exp_addr.delete();
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++)
        if (exp_addr.size() < max_n)
          exp_addr.push_back(ab + 32'(yy) * as + 32'(xx) * 32'd4);
  endtask

  task automatic compare_stream(input string tag, input logic [31:0] col);
    check({tag, "_len"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), obs_data[i], col);
    end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.slave_address    = a;
    bus.slave_writedata  = d;
    bus.slave_write      = 1'b1;
    bus.slave_chipselect = 1'b1;
    @(negedge clk);
    bus.slave_write      = 1'b0;
    bus.slave_chipselect = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.slave_address    = a;
    bus.slave_read       = 1'b1;
    bus.slave_chipselect = 1'b1;
    @(negedge clk);
    bus.slave_read       = 1'b0;
    bus.slave_chipselect = 1'b0;
    d = bus.slave_readdata;
  endtask

  task automatic configure(input logic [31:0] b, input logic [31:0] s,
                           input int x0, input int y0, input int x1,
                           input int y1, input logic [31:0] col);
    csr_write(R_BASE, b);
    csr_write(R_STRIDE, s);
    csr_write(R_ORIGIN, (32'(y0) << 16) | 32'(x0));
    csr_write(R_EXTENT, (32'(y1) << 16) | 32'(x1));
    csr_write(R_COLOR, col);
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] s;
    s = 32'h1;
    for (int i = 0; i < budget && s[0]; i++) csr_read(R_STATUS, s);
    check("idle_reached", s[0], 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] v;
    for (int r = 0; r < 8; r++) begin
      csr_read(3'(r), v);
      check($sformatf("%s_reg%0d", tag, r), v, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] v, rb, rs, rc;
    int rx0, ry0, rx1, ry1, hi;

    bus.slave_address    = '0;
    bus.slave_writedata  = '0;
    bus.slave_write      = 1'b0;
    bus.slave_read       = 1'b0;
    bus.slave_chipselect = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_write", bus.master_write, 1'b0);
    check("rst_addr", bus.master_address, 32'h0);
    check("rst_data", bus.master_writedata, 32'h0);
    check("rst_irq", bus.irq, 1'b0);
    check("rst_rdata", bus.slave_readdata, 32'h0);
    reset_n = 1'b1;
    check_all_zero("rst");

    // Directed fill, no stalls, with cycle-exact timing
    configure(32'h0800_0000, 32'd2560, 2, 1, 4, 2, 32'h00FF_0000);
    build_expected(32'h0800_0000, 32'd2560, 2, 1, 4, 2, 1 << 30);
    obs_addr.delete(); obs_data.delete();
    csr_write(R_CTRL, 32'h1);
    check("a_setup_no_write", bus.master_write, 1'b0);
    @(negedge clk);
    check("a_first_write", bus.master_write, 1'b1);
    check("a_first_addr", bus.master_address, 32'h0800_0A08);
    hi = 0;
    for (int i = 0; i < 50 && bus.master_write; i++) begin
      hi++;
      @(negedge clk);
    end
    check("a_write_cycles", hi, 6);
    check("a_irq_off", bus.irq, 1'b0);
    compare_stream("a", 32'h00FF_0000);
    csr_read(R_COUNT, v);  check("a_count", v, 32'd6);
    csr_read(R_STATUS, v); check("a_status", v, 32'h2);

    // Same with random stalls
    stall_mode = 1;
    obs_addr.delete(); obs_data.delete();
    csr_write(R_CTRL, 32'h1);
    wait_idle(200);
    compare_stream("b", 32'h00FF_0000);
    csr_read(R_COUNT, v);  check("b_count", v, 32'd6);
    csr_read(R_STATUS, v); check("b_status", v, 32'h2);

    // Random geometries against the model
    for (int it = 0; it < 6; it++) begin
      rb  = $urandom;
      rs  = $urandom_range(0, 8192);
      rc  = $urandom;
      rx0 = $urandom_range(0, 2040);
      ry0 = $urandom_range(0, 2040);
      rx1 = rx0 + $urandom_range(0, 5);
      ry1 = ry0 + $urandom_range(0, 3);
      stall_mode = $urandom_range(0, 1);
      configure(rb, rs, rx0, ry0, rx1, ry1, rc);
      csr_read(R_BASE, v);   check("c_base_rb", v, rb & ~32'h3);
      csr_read(R_ORIGIN, v); check("c_origin_rb", v, (32'(ry0) << 16) | 32'(rx0));
      build_expected(rb, rs, rx0, ry0, rx1, ry1, 1 << 30);
      obs_addr.delete(); obs_data.delete();
      csr_write(R_CTRL, 32'h1);
      wait_idle(500);
      compare_stream($sformatf("c%0d", it), rc);
      csr_read(R_COUNT, v);  check("c_count", v, 32'(exp_addr.size()));
      csr_read(R_STATUS, v); check("c_status", v, 32'h2);
    end
    stall_mode = 0;

    // Inverted geometry: error, no traffic
    configure(32'h0, 32'd16, 5, 0, 3, 0, 32'h1);
    obs_addr.delete(); obs_data.delete();
    csr_write(R_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    check("d_x_no_traffic", obs_addr.size(), 0);
    csr_read(R_STATUS, v); check("d_x_status", v, 32'h6);
    csr_write(R_STATUS, 32'hE);
    csr_read(R_STATUS, v); check("d_w1c", v, 32'h0);
    configure(32'h0, 32'd16, 0, 4, 0, 1, 32'h1);
    csr_write(R_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    check("d_y_no_traffic", obs_addr.size(), 0);
    csr_read(R_STATUS, v); check("d_y_status", v, 32'h6);

    // Writes while busy are ignored; irq timing and W1C clear
    csr_write(R_CTRL, 32'h4);
    configure(32'h100, 32'h400, 0, 0, 31, 3, 32'h1234_5678);
    build_expected(32'h100, 32'h400, 0, 0, 31, 3, 1 << 30);
    obs_addr.delete(); obs_data.delete();
    csr_write(R_CTRL, 32'h5);
    csr_read(R_STATUS, v); check("e_busy", v, 32'h1);
    csr_write(R_COLOR, 32'h0000_00FF);
    csr_write(R_BASE, 32'hDEAD_0000);
    csr_read(R_COLOR, v); check("e_color_locked", v, 32'h1234_5678);
    csr_read(R_BASE, v);  check("e_base_locked", v, 32'h100);
    csr_read(R_CTRL, v);  check("e_ctrl_rb", v, 32'h4);
    for (int i = 0; i < 300 && bus.master_write; i++) @(negedge clk);
    check("e_write_done", bus.master_write, 1'b0);
    check("e_irq_rise", bus.irq, 1'b1);
    compare_stream("e", 32'h1234_5678);
    csr_write(R_STATUS, 32'h2);
    check("e_irq_clear", bus.irq, 1'b0);
    csr_read(R_STATUS, v); check("e_status_clear", v, 32'h0);
    csr_write(R_CTRL, 32'h0);

    // 640x480 fill aborted after 100 accepts while stalled
    rc = $urandom;
    configure(32'h0, 32'd2560, 0, 0, 639, 479, rc);
    build_expected(32'h0, 32'd2560, 0, 0, 639, 479, 101);
    obs_addr.delete(); obs_data.delete();
    csr_write(R_CTRL, 32'h1);
    for (int i = 0; i < 1000 && obs_addr.size() < 100; i++) begin
      @(negedge clk);
      #2;
    end
    check("f_reached_100", obs_addr.size(), 100);
    @(posedge clk);
    #2 force_wait = 1'b1;
    csr_write(R_CTRL, 32'h2);
    repeat (3) @(negedge clk);
    check("f_held_write", bus.master_write, 1'b1);
    check("f_held_addr", bus.master_address, exp_addr[100]);
    force_wait = 1'b0;
    wait_idle(50);
    compare_stream("f", rc);
    csr_read(R_COUNT, v);  check("f_count", v, 32'd101);
    csr_read(R_STATUS, v); check("f_status", v, 32'hA);
    csr_write(R_STATUS, 32'hE);

    // Reset in the middle of a fill
    configure(32'h2000, 32'h100, 0, 0, 63, 3, 32'hCAFE_F00D);
    csr_write(R_CTRL, 32'h5);
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("g_async_drop", bus.master_write, 1'b0);
    check("g_addr_rst", bus.master_address, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    check_all_zero("g");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
